// File: rtl/pe_array_n.sv
// Linear systolic chain of NUM_PE Smith-Waterman cells with run control and a registered best score.
// Optional macro PE_ARRAY_BEST_COL_EN adds best_col, the 1-based target column of the best cell.

module pe_cell #(
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    s,
  input  logic [1:0]    tIn,
  input  logic [VW-1:0] vIn,
  input  logic [VW-1:0] vAlphaIn,
  input  logic [VW-1:0] fIn,
  input  logic          newLineIn,
  input  logic [VW-1:0] minusAlpha,
  input  logic [VW-1:0] minusBeta,
  input  logic [VW-1:0] match,
  input  logic [VW-1:0] mismatch,
  output logic [1:0]    tOut,
  output logic [VW-1:0] vOut,
  output logic [VW-1:0] vAlphaOut,
  output logic [VW-1:0] fOut,
  output logic          newLineOut
);

  function automatic logic [VW-1:0] satSub(input logic [VW-1:0] a, input logic [VW-1:0] b);
    if (a > b) satSub = a - b;
    else       satSub = {VW{1'b0}};
  endfunction

  function automatic logic [VW-1:0] satAdd(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[VW]) satAdd = {VW{1'b1}};
    else         satAdd = sum[VW-1:0];
  endfunction

  function automatic logic [VW-1:0] max2(input logic [VW-1:0] a, input logic [VW-1:0] b);
    if (a > b) max2 = a;
    else       max2 = b;
  endfunction

  logic [VW-1:0] e_r, vDiag_r;
  logic [VW-1:0] hUp_s, eOld_s, diag_s, eNew_s, fNew_s, sub_s, hNew_s;

  // A new target line restarts the column: up, diagonal and E history read as zero.
  always_comb begin
    hUp_s  = newLineIn ? {VW{1'b0}} : vOut;
    eOld_s = newLineIn ? {VW{1'b0}} : e_r;
    diag_s = newLineIn ? {VW{1'b0}} : vDiag_r;
    eNew_s = max2(satSub(hUp_s, minusAlpha), satSub(eOld_s, minusBeta));
    fNew_s = max2(vAlphaIn, satSub(fIn, minusBeta));
    sub_s  = (s == tIn) ? satAdd(diag_s, match) : satSub(diag_s, mismatch);
    hNew_s = max2(max2(sub_s, eNew_s), fNew_s);
  end

  // Cell state advances only on enabled beats; chain outputs hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tOut       <= 2'd0;
      vOut       <= {VW{1'b0}};
      vAlphaOut  <= {VW{1'b0}};
      fOut       <= {VW{1'b0}};
      newLineOut <= 1'b0;
      e_r        <= {VW{1'b0}};
      vDiag_r    <= {VW{1'b0}};
    end else if (en) begin
      tOut       <= tIn;
      vOut       <= hNew_s;
      vAlphaOut  <= satSub(hNew_s, minusAlpha);
      fOut       <= fNew_s;
      newLineOut <= newLineIn;
      e_r        <= eNew_s;
      vDiag_r    <= vIn;
    end
  end

endmodule

module pe_array_n #(
  parameter int NUM_PE = 8,
  parameter int VW     = 16,
  parameter int IDXW   = $clog2(NUM_PE)
`ifdef PE_ARRAY_BEST_COL_EN
  , parameter int COLW = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*NUM_PE-1:0]  s_in,
  input  logic [IDXW:0]        seg_len,
  input  logic                 t_valid,
  input  logic                 t_last,
  input  logic [1:0]           t_in,
  input  logic                 new_line_in,
  input  logic [VW-1:0]        v_in,
  input  logic [VW-1:0]        v_alpha_in,
  input  logic [VW-1:0]        f_in,
  output logic [VW-1:0]        v_out,
  output logic [VW-1:0]        v_alpha_out,
  output logic [VW-1:0]        f_out,
  output logic [1:0]           t_out,
  output logic                 new_line_out,
  input  logic [VW-1:0]        minus_alpha,
  input  logic [VW-1:0]        minus_beta,
  input  logic [VW-1:0]        match,
  input  logic [VW-1:0]        mismatch,
  output logic                 busy,
  output logic                 done,
  output logic [VW-1:0]        best,
  output logic [IDXW-1:0]      best_idx
`ifdef PE_ARRAY_BEST_COL_EN
  , output logic [COLW-1:0]    best_col
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [IDXW:0] NumPeL = (IDXW+1)'(NUM_PE);

  state_t              state_r, stateNext_s;
  logic [2*NUM_PE-1:0] sQ_r;
  logic [IDXW:0]       lenQ_r, lenClamp_s;
  logic [NUM_PE-1:0]   maskQ_r, maskNext_s, vld_s, en_s, enPrev_r;
  logic [NUM_PE-2:0]   vldQ_r;
  logic [IDXW+1:0]     drainCnt_r, lenEnd_s;
  logic                accept_s, launch_s;
  logic [VW-1:0]       cmax_s, cmaxQ_r;
  logic [IDXW-1:0]     cidx_s, cidxQ_r;
  logic                cval_s, cvalQ_r;

  logic [1:0]    tCh_s  [NUM_PE+1];
  logic [VW-1:0] vCh_s  [NUM_PE+1];
  logic [VW-1:0] vaCh_s [NUM_PE+1];
  logic [VW-1:0] fCh_s  [NUM_PE+1];
  logic          nlCh_s [NUM_PE+1];

  assign accept_s = t_valid & (state_r == RUN);
  assign launch_s = start & (state_r == IDLE);
  assign lenEnd_s = {1'b0, lenQ_r} + {{(IDXW+1){1'b0}}, 1'b1};
  assign busy     = (state_r != IDLE);

  // Out-of-range segment lengths run the full chain.
  always_comb begin
    if ((seg_len == {(IDXW+1){1'b0}}) || (seg_len > NumPeL)) lenClamp_s = NumPeL;
    else                                                      lenClamp_s = seg_len;
    for (int k = 0; k < NUM_PE; k++) maskNext_s[k] = ((IDXW+1)'(k) < lenClamp_s);
  end

  // Next-state logic: starts are only honoured from IDLE.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE:    if (start)               stateNext_s = RUN;   else stateNext_s = IDLE;
      RUN:     if (accept_s && t_last)  stateNext_s = DRAIN; else stateNext_s = RUN;
      DRAIN:   if (drainCnt_r == lenEnd_s) stateNext_s = IDLE; else stateNext_s = DRAIN;
      default: stateNext_s = IDLE;
    endcase
  end

  // Run control registers; done fires on the last drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sQ_r       <= {(2*NUM_PE){1'b0}};
      lenQ_r     <= {(IDXW+1){1'b0}};
      maskQ_r    <= {NUM_PE{1'b0}};
      drainCnt_r <= {(IDXW+2){1'b0}};
      done       <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      if (launch_s) begin
        sQ_r    <= s_in;
        lenQ_r  <= lenClamp_s;
        maskQ_r <= maskNext_s;
      end
      if (state_r == DRAIN) drainCnt_r <= drainCnt_r + {{(IDXW+1){1'b0}}, 1'b1};
      else                  drainCnt_r <= {(IDXW+2){1'b0}};
      done <= (state_r == DRAIN) && (drainCnt_r == {1'b0, lenQ_r});
    end
  end

  assign vld_s = {vldQ_r, accept_s};
  assign en_s  = vld_s & maskQ_r;

  assign tCh_s[0]  = t_in;
  assign vCh_s[0]  = v_in;
  assign vaCh_s[0] = v_alpha_in;
  assign fCh_s[0]  = f_in;
  assign nlCh_s[0] = new_line_in;

  genvar g;
  generate
    for (g = 0; g < NUM_PE; g++) begin : gPe
      pe_cell #(.VW(VW)) uPe (
        .clk(clk), .rst_n(rst_n), .en(en_s[g]), .s(sQ_r[2*g+1:2*g]),
        .tIn(tCh_s[g]), .vIn(vCh_s[g]), .vAlphaIn(vaCh_s[g]), .fIn(fCh_s[g]),
        .newLineIn(nlCh_s[g]), .minusAlpha(minus_alpha), .minusBeta(minus_beta),
        .match(match), .mismatch(mismatch),
        .tOut(tCh_s[g+1]), .vOut(vCh_s[g+1]), .vAlphaOut(vaCh_s[g+1]),
        .fOut(fCh_s[g+1]), .newLineOut(nlCh_s[g+1])
      );
    end
  endgenerate

  assign t_out        = tCh_s[NUM_PE];
  assign v_out        = vCh_s[NUM_PE];
  assign v_alpha_out  = vaCh_s[NUM_PE];
  assign f_out        = fCh_s[NUM_PE];
  assign new_line_out = nlCh_s[NUM_PE];

`ifdef PE_ARRAY_BEST_COL_EN
  logic [COLW-1:0] colCnt_r, colHead_s, ccol_s, ccolQ_r;
  logic [COLW-1:0] colStage_s [NUM_PE];
  logic [COLW-1:0] colPipe_r  [NUM_PE-1];
  logic [COLW-1:0] colPrev_r  [NUM_PE];

  assign colHead_s     = (&colCnt_r) ? colCnt_r : colCnt_r + {{(COLW-1){1'b0}}, 1'b1};
  assign colStage_s[0] = colHead_s;
  for (genvar c = 1; c < NUM_PE; c++) begin : gColStage
    assign colStage_s[c] = colPipe_r[c-1];
  end

  // Column tags ride alongside the valid pipeline so each candidate knows its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colCnt_r <= {COLW{1'b0}};
      for (int k = 0; k < NUM_PE-1; k++) colPipe_r[k] <= {COLW{1'b0}};
      for (int k = 0; k < NUM_PE; k++)   colPrev_r[k] <= {COLW{1'b0}};
    end else begin
      if (launch_s)      colCnt_r <= {COLW{1'b0}};
      else if (accept_s) colCnt_r <= colHead_s;
      for (int k = 0; k < NUM_PE-1; k++) colPipe_r[k] <= colStage_s[k];
      for (int k = 0; k < NUM_PE; k++)   colPrev_r[k] <= colStage_s[k];
    end
  end
`endif

  // Candidate is the highest freshly updated cell; ascending scan keeps the lowest index on ties.
  always_comb begin
    cmax_s = {VW{1'b0}};
    cidx_s = {IDXW{1'b0}};
    cval_s = 1'b0;
`ifdef PE_ARRAY_BEST_COL_EN
    ccol_s = {COLW{1'b0}};
`endif
    for (int k = 0; k < NUM_PE; k++) begin
      if (enPrev_r[k] && (!cval_s || (vCh_s[k+1] > cmax_s))) begin
        cmax_s = vCh_s[k+1];
        cidx_s = IDXW'(k);
        cval_s = 1'b1;
`ifdef PE_ARRAY_BEST_COL_EN
        ccol_s = colPrev_r[k];
`endif
      end else begin
        cval_s = cval_s;
      end
    end
  end

  // Max stage register and best tracker; strictly greater keeps the earliest maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldQ_r   <= {(NUM_PE-1){1'b0}};
      enPrev_r <= {NUM_PE{1'b0}};
      cmaxQ_r  <= {VW{1'b0}};
      cidxQ_r  <= {IDXW{1'b0}};
      cvalQ_r  <= 1'b0;
      best     <= {VW{1'b0}};
      best_idx <= {IDXW{1'b0}};
`ifdef PE_ARRAY_BEST_COL_EN
      ccolQ_r  <= {COLW{1'b0}};
      best_col <= {COLW{1'b0}};
`endif
    end else begin
      vldQ_r   <= vld_s[NUM_PE-2:0];
      enPrev_r <= en_s;
      cmaxQ_r  <= cmax_s;
      cidxQ_r  <= cidx_s;
      cvalQ_r  <= cval_s;
`ifdef PE_ARRAY_BEST_COL_EN
      ccolQ_r  <= ccol_s;
`endif
      if (launch_s) begin
        best     <= {VW{1'b0}};
        best_idx <= {IDXW{1'b0}};
`ifdef PE_ARRAY_BEST_COL_EN
        best_col <= {COLW{1'b0}};
`endif
      end else if (cvalQ_r && (cmaxQ_r > best)) begin
        best     <= cmaxQ_r;
        best_idx <= cidxQ_r;
`ifdef PE_ARRAY_BEST_COL_EN
        best_col <= ccolQ_r;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pe_array_n.sv
// Self-checking bench for pe_array_n (NUM_PE=4): table-driven runs with a scoreboard queue.
module tb_pe_array_n;
  localparam int NUM_PE = 4;
  localparam int VW     = 16;
  localparam int IDXW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, t_valid, t_last, new_line_in, new_line_out, busy, done;
  logic [7:0] s_in;
  logic [2:0] seg_len;
  logic [1:0] t_in, t_out, best_idx;
  logic [VW-1:0] v_in, v_alpha_in, f_in, v_out, v_alpha_out, f_out;
  logic [VW-1:0] minus_alpha, minus_beta, match, mismatch, best;
`ifdef PE_ARRAY_BEST_COL_EN
  logic [15:0] best_col;
`endif

  pe_array_n #(.NUM_PE(NUM_PE), .VW(VW), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_in(s_in), .seg_len(seg_len),
    .t_valid(t_valid), .t_last(t_last), .t_in(t_in), .new_line_in(new_line_in),
    .v_in(v_in), .v_alpha_in(v_alpha_in), .f_in(f_in),
    .v_out(v_out), .v_alpha_out(v_alpha_out), .f_out(f_out), .t_out(t_out),
    .new_line_out(new_line_out), .minus_alpha(minus_alpha), .minus_beta(minus_beta),
    .match(match), .mismatch(mismatch), .busy(busy), .done(done),
    .best(best), .best_idx(best_idx)
`ifdef PE_ARRAY_BEST_COL_EN
    , .best_col(best_col)
`endif
  );

  typedef struct {
    logic [7:0]  s;
    logic [2:0]  segLen;
    int          nBeats;
    logic [11:0] tSeq;
    logic [15:0] expBest;
    logic [1:0]  expIdx;
    int          expLat;
    logic [15:0] expCol;
  } vec_t;

  typedef struct {
    logic [15:0] best;
    logic [1:0]  idx;
    int          lat;
    logic [15:0] col;
  } exp_t;

  vec_t vecs [7];
  exp_t sbq [$];
  int checks = 0;
  int errors = 0;
  int hiEnCnt = 0;
  int doneCnt = 0;
  logic monHi = 1'b0;

  always @(posedge clk) begin
    if (monHi && (dut.en_s[2] || dut.en_s[3])) hiEnCnt <= hiEnCnt + 1;
    if (done) doneCnt <= doneCnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input string name, input bit gap, input bit dupStart);
    exp_t e;
    int lat;
    e.best = v.expBest; e.idx = v.expIdx; e.lat = v.expLat; e.col = v.expCol;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; s_in = v.s; seg_len = v.segLen;
    @(posedge clk); #1;
    start = 1'b0; s_in = 8'hFF; seg_len = 3'd1;
    check({name, "_busy_run"}, busy, 1);
    check({name, "_best_clr"}, best, 0);
    for (int i = 0; i < v.nBeats; i++) begin
      if (gap && i == 2) begin
        t_valid = 1'b0; t_last = 1'b0; new_line_in = 1'b0; start = dupStart;
        repeat (3) begin @(posedge clk); #1; start = 1'b0; end
      end
      t_valid = 1'b1; t_in = v.tSeq[2*i +: 2];
      t_last = (i == v.nBeats - 1); new_line_in = (i == 0);
      @(posedge clk); #1;
    end
    t_valid = 1'b0; t_last = 1'b0; new_line_in = 1'b0; t_in = 2'd0;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    check({name, "_done_seen"}, done, 1);
    if (sbq.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      check({name, "_latency"}, lat, e.lat);
      check({name, "_best"}, best, e.best);
      check({name, "_best_idx"}, best_idx, e.idx);
`ifdef PE_ARRAY_BEST_COL_EN
      check({name, "_best_col"}, best_col, e.col);
`endif
    end
    check({name, "_busy_at_done"}, busy, 1);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_best_hold"}, best, v.expBest);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    // s: PE k base at [2k+1:2k]; t: beat i at [2i+1:2i]. ACGT=E4, TTTT=FF.
    vecs[0] = '{8'hE4, 3'd4, 4, 12'h0E4, 16'd8, 2'd3, 6, 16'd4};
    vecs[1] = '{8'hE4, 3'd2, 4, 12'h0E4, 16'd4, 2'd1, 4, 16'd2};
    vecs[2] = '{8'hFF, 3'd4, 4, 12'h000, 16'd0, 2'd0, 6, 16'd0};
    vecs[3] = '{8'hE4, 3'd0, 4, 12'h0E4, 16'd8, 2'd3, 6, 16'd4};
    vecs[4] = '{8'hE4, 3'd1, 4, 12'h000, 16'd2, 2'd0, 3, 16'd1};
    vecs[5] = '{8'hE4, 3'd5, 4, 12'h0E4, 16'd8, 2'd3, 6, 16'd4};
    vecs[6] = '{8'hE4, 3'd4, 6, 12'hE4A, 16'd8, 2'd3, 6, 16'd6};

    rst_n = 1'b0; start = 1'b0; t_valid = 1'b0; t_last = 1'b0; new_line_in = 1'b0;
    s_in = 8'h00; seg_len = 3'd4; t_in = 2'd0;
    v_in = 16'd0; v_alpha_in = 16'd0; f_in = 16'd0;
    match = 16'd2; mismatch = 16'd1; minus_alpha = 16'd2; minus_beta = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best", best, 0);
    check("rst_best_idx", best_idx, 0);
    rst_n = 1'b1;

    runVec(vecs[0], "acgt_len4", 1'b0, 1'b0);
    monHi = 1'b1;
    runVec(vecs[1], "acgt_len2", 1'b0, 1'b0);
    monHi = 1'b0;
    check("len2_hi_enable_count", hiEnCnt, 0);
    runVec(vecs[0], "acgt_after_len2", 1'b0, 1'b0);
    runVec(vecs[2], "tttt_aaaa", 1'b0, 1'b0);
    runVec(vecs[0], "acgt_after_zero", 1'b0, 1'b0);
    for (int i = 3; i < 6; i++) runVec(vecs[i], $sformatf("table_%0d", i), 1'b0, 1'b0);
    runVec(vecs[0], "gap_dup_start", 1'b1, 1'b1);

    // Abort a run two cycles after start.
    @(posedge clk); #1;
    start = 1'b1; s_in = 8'hE4; seg_len = 3'd4;
    @(posedge clk); #1;
    start = 1'b0; t_valid = 1'b1; t_in = 2'd0; new_line_in = 1'b1;
    @(posedge clk); #1;
    t_valid = 1'b0; new_line_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_best", best, 0);
    check("abort_done", done, 0);
    check("abort_best_idx", best_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    snap = doneCnt;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", doneCnt, snap);
    runVec(vecs[0], "after_abort", 1'b0, 1'b0);

`ifdef PE_ARRAY_BEST_COL_EN
    runVec(vecs[6], "ggacgt_col", 1'b0, 1'b0);
`endif

    check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_array_n.md
Name: pe_array_n

Overview:
- Parametrised successor of the two-PE array: a linear systolic chain of NUM_PE copies of the existing PE cell that computes one Smith-Waterman query segment against a streamed target.
- Adds, beyond a fixed two-cell array with a combinational max:
  - run control (start/busy/done);
  - a programmable active length;
  - per-cell valid tracking;
  - a registered running best score with the index of the PE that produced it.
- Sits between the sequence loader (query/target feed) and the score collector.

Parameters:
- NUM_PE, 8, number of chained PE cells (>=2).
- VW, 16, score/V/E/F width in bits (same meaning as V_E_F_Bit).
- IDXW, $clog2(NUM_PE), width of PE index / length fields.
- COLW, 16, width of the column counter (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches query and seg_len, clears best.
- s_in  in  2*NUM_PE  query bases; PE k uses s_in[2k+1:2k]. Encoding: A=0, C=1, G=2, T=3.
- seg_len  in  IDXW+1  number of active PEs, 1..NUM_PE.
- t_valid  in  1  target base valid this cycle.
- t_last  in  1  qualifies the final target base.
- t_in  in  2  target base.
- new_line_in  in  1  forwarded to PE 0 newLineIn.
- v_in, v_alpha_in, f_in  in  VW each  boundary inputs to PE 0.
- v_out, v_alpha_out, f_out  out  VW each  outputs of PE NUM_PE-1.
- t_out  out  2  target out of PE NUM_PE-1.
- new_line_out  out  1  newLineOut of PE NUM_PE-1.
- minus_alpha, minus_beta, match, mismatch  in  VW each  scoring constants, broadcast to all PEs.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- best  out  VW  running best local score.
- best_idx  out  IDXW  PE index of best.

Behaviour:
- Reset: busy=0, done=0, best=0, best_idx=0, all valid/mask registers 0. PE cells are reset through rst_n.
- FSM states:
  - IDLE → RUN on start; latches s_q, len_q, mask_q[k]=(k<len_q); best<=0, best_idx<=0.
  - RUN → DRAIN on an accepted beat with t_last (accepted = t_valid & busy).
  - DRAIN → IDLE when the drain counter reaches len_q+1; done=1 for exactly that cycle.
- busy=1 in RUN and DRAIN.
- start is ignored while busy.
- t_valid outside RUN is ignored.
- seg_len of 0 or >NUM_PE is clamped to NUM_PE.
- Valid pipeline:
  - vld[0] = t_valid & (state==RUN); vld[k] <= vld[k-1].
  - PE enable[k] = vld[k] & mask_q[k], so PEs k>=len_q never enable.
- Chain: t, v, v_alpha, f and newLine are wired PE k → PE k+1; s of PE k is s_q[2k+1:2k].
- Max stage (registered):
  - cand = max over k of vOut(PE k) for PEs whose enable was high the previous cycle.
  - Lowest index wins ties.
  - Registered as cmax_q / cidx_q / cval_q.
  - Scores are treated as unsigned VW-bit values (cells clamp at 0).
- Best update: if cval_q & (cmax_q > best), then best<=cmax_q and best_idx<=cidx_q. Strictly greater, so the earliest maximum is kept.
- Latency: the last beat's cell in PE len_q-1 is reflected in best by the cycle done pulses.
  - done pulses len_q+2 cycles after the accepted t_last beat.
- best/best_idx hold after done until the next start.
- Simultaneous t_last and start: start is ignored (busy).
- rst_n low mid-run: immediate return to IDLE, all outputs to reset values, no done.

Optional Feature:
- Macro: PE_ARRAY_BEST_COL_EN.
- Defined:
  - Adds output best_col [COLW-1:0]: the 1-based target column of the cell that produced best.
  - Implementation: a COLW-bit counter of accepted beats, cleared on start; its value travels with the valid pipeline and is latched with best.
  - Reset/start value 0; the counter saturates at all-ones.
- Undefined: no port, no counter.

Test Plan:
- Common configuration for all scenarios: NUM_PE=4, VW=16, match=2, mismatch=1 (subtracted), alpha=2, beta=1.
- s=ACGT, seg_len=4, t=ACGT (4 consecutive beats, t_last on beat 4) → best=8, best_idx=3, done exactly 6 cycles after beat 4, busy drops with done.
- s=ACGT, seg_len=2, t=ACGT → best=4, best_idx=1; enable[2], enable[3] never asserted.
- s=TTTT, seg_len=4, t=AAAA → best=0, best_idx=0, done after 6 cycles; then start with s=ACGT, t=ACGT → best cleared, ends at 8.
- start pulsed during RUN and t_valid gaps (t_valid low 3 cycles mid-stream) → second start ignored; result identical to the gapless run; done timing counted from t_last.
- rst_n asserted 2 cycles after start, then released and a new run issued → busy=0 and best=0 immediately, no done pulse for the aborted run, new run correct.
- With PE_ARRAY_BEST_COL_EN, s=ACGT, t=GGACGT → best=8, best_col=6; without the macro, the design compiles with no best_col port.
